// File: rtl/scytale_decryption_pkg.sv
// Shared constants, state encoding and key-field helpers for the scytale decryptor.
// The SCYTALE_ERR_EN build option is handled in the interface and top files.
package decryption_pkg;

    localparam int D_WIDTH       = 8;
    localparam int KEY_WIDTH     = 8;
    localparam int MAX_NOF_CHARS = 50;
    localparam logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA;

    // Write counter must be able to hold MAX_NOF_CHARS itself (the "full" value).
    localparam int CNT_W = $clog2(MAX_NOF_CHARS + 1);
    localparam int IDX_W = 2 * KEY_WIDTH;

    localparam int KEY_N_LSB = KEY_WIDTH;
    localparam int KEY_M_LSB = 0;

    typedef enum logic {
        IDLE,
        DECRYPT
    } state_e;

    function automatic logic [KEY_WIDTH-1:0] key_n(input logic [2*KEY_WIDTH-1:0] key);
        return key[KEY_N_LSB +: KEY_WIDTH];
    endfunction

    function automatic logic [KEY_WIDTH-1:0] key_m(input logic [2*KEY_WIDTH-1:0] key);
        return key[KEY_M_LSB +: KEY_WIDTH];
    endfunction

endpackage

// File: rtl/scytale_decryption_if.sv
// Upstream/downstream signal bundle of the scytale decryptor.
// Defining SCYTALE_ERR_EN adds the err_o pulse output.
interface scytale_decryption_if;
    import decryption_pkg::*;

    logic [D_WIDTH-1:0]     data_i;
    logic                   valid_i;
    logic [2*KEY_WIDTH-1:0] key;
    logic                   busy;
    logic [D_WIDTH-1:0]     data_o;
    logic                   valid_o;

`ifdef SCYTALE_ERR_EN
    logic                   err_o;

    modport master (output data_i, valid_i, key, input busy, data_o, valid_o, err_o);
    modport slave  (input data_i, valid_i, key, output busy, data_o, valid_o, err_o);
`else
    modport master (output data_i, valid_i, key, input busy, data_o, valid_o);
    modport slave  (input data_i, valid_i, key, output busy, data_o, valid_o);
`endif

endinterface

// File: rtl/scytale_index_gen.sv
// Row/column walker producing the ciphertext index col*M + row using additions only.
// Column advances fastest; last flags the final (M-1, N-1) position.
module scytale_index_gen
    import decryption_pkg::*;
(
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 step_i,
    input  logic [KEY_WIDTH-1:0] n_i,
    input  logic [KEY_WIDTH-1:0] m_i,
    output logic [IDX_W-1:0]     index_o,
    output logic                 last_o
);

    logic [KEY_WIDTH-1:0] row_q, row_d;
    logic [KEY_WIDTH-1:0] col_q, col_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic                 col_wrap;

    assign col_wrap = (col_q == n_i - KEY_WIDTH'(1));

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
        row_d   = row_q;
        col_d   = col_q;
        index_d = index_q;
        if (start_i) begin
            row_d   = '0;
            col_d   = '0;
            index_d = '0;
        end else if (step_i) begin
            if (col_wrap) begin
                // New row starts at column 0, whose index is simply the new row number.
                col_d   = '0;
                row_d   = row_q + KEY_WIDTH'(1);
                index_d = IDX_W'(row_q) + IDX_W'(1);
            end else begin
                col_d   = col_q + KEY_WIDTH'(1);
                index_d = index_q + IDX_W'(m_i);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            row_q   <= '0;
            col_q   <= '0;
            index_q <= '0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            index_q <= index_d;
        end
    end

    assign index_o = index_q;
    assign last_o  = col_wrap && (row_q == m_i - KEY_WIDTH'(1));

endmodule

// File: rtl/scytale_decryption.sv
// Scytale decryptor: buffers one message until the start token, then replays it in plaintext order.
// Defining SCYTALE_ERR_EN adds err_o, pulsing on buffer overflow or length/key mismatch.
module scytale_decryption
    import decryption_pkg::*;
(
    input  logic                 clk_sys,
    input  logic                 rst_n,
    scytale_decryption_if.slave  bus
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic [KEY_WIDTH-1:0] key_n_q, key_n_d;
    logic [KEY_WIDTH-1:0] key_m_q, key_m_d;
    logic [D_WIDTH-1:0]   buffer_q [MAX_NOF_CHARS];

    logic [IDX_W-1:0]     index;
    logic                 last;
    logic                 busy, degenerate, out_valid, finish;
    logic                 accept, is_token, store, go;

    assign busy       = (state_q == DECRYPT);
    assign degenerate = (key_n_q == '0) || (key_m_q == '0);
    assign out_valid  = busy && !degenerate;
    assign finish     = busy && (degenerate || last);

    // Input is only looked at while collecting; anything sent during replay is ignored.
    assign accept   = (state_q == IDLE) && bus.valid_i;
    assign is_token = (bus.data_i == START_DECRYPTION_TOKEN);
    assign store    = accept && !is_token && (wr_cnt_q < CNT_W'(MAX_NOF_CHARS));
    assign go       = accept && is_token && (wr_cnt_q != '0);

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        len_d    = len_q;
        key_n_d  = key_n_q;
        key_m_d  = key_m_q;
        case (state_q)
            IDLE: begin
                if (store) wr_cnt_d = wr_cnt_q + CNT_W'(1);
                if (go) begin
                    state_d = DECRYPT;
                    len_d   = wr_cnt_q;
                    key_n_d = key_n(bus.key);
                    key_m_d = key_m(bus.key);
                end
            end
            DECRYPT: begin
                if (finish) begin
                    state_d  = IDLE;
                    wr_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_cnt_q <= '0;
            len_q    <= '0;
            key_n_q  <= '0;
            key_m_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            len_q    <= len_d;
            key_n_q  <= key_n_d;
            key_m_q  <= key_m_d;
        end
    end

    // NOTE: the message buffer is deliberately not reset; wr_cnt/len_q gate every read of it.
    always_ff @(posedge clk_sys) begin
        if (store) buffer_q[wr_cnt_q] <= bus.data_i;
    end

    scytale_index_gen u_index_gen (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .start_i ((state_q == IDLE) || finish),
        .step_i  (out_valid && !last),
        .n_i     (key_n_q),
        .m_i     (key_m_q),
        .index_o (index),
        .last_o  (last)
    );

    // Positions past the received length of a short message are padded with zero.
    assign bus.busy    = busy;
    assign bus.valid_o = out_valid;
    assign bus.data_o  = (out_valid && (index < IDX_W'(len_q))) ? buffer_q[index[CNT_W-1:0]] : '0;

`ifdef SCYTALE_ERR_EN
    logic             err_q, err_d;
    logic             drop;
    logic [IDX_W-1:0] key_area;

    assign drop     = accept && !is_token && (wr_cnt_q == CNT_W'(MAX_NOF_CHARS));
    assign key_area = IDX_W'(key_n(bus.key)) * IDX_W'(key_m(bus.key));
    assign err_d    = drop || (go && (IDX_W'(wr_cnt_q) != key_area));

    always_ff @(posedge clk_sys) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus.err_o = err_q;
`endif

endmodule

// File: tb/tb_scytale_decryption.sv
// Scoreboard bench for scytale_decryption: stimulus pushes expected plaintext, a negedge monitor pops and compares.
// Also exercises err_o when built with SCYTALE_ERR_EN.
module tb_scytale_decryption;
    import decryption_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic mon_en = 1'b0;

    scytale_decryption_if bus();

    scytale_decryption dut (
        .clk_sys (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int failures    = 0;
    int busy_cycles = 0;
    int err_pulses  = 0;
    logic [7:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid byte must match the head of the scoreboard; idle data must be zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.valid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got 0x%0h expected no output at %0t", bus.data_o, $time);
                end else begin
                    check("out_byte", bus.data_o, sb.pop_front());
                end
            end else begin
                check("idle_data_zero", bus.data_o, 32'h0);
            end
        end
    end

`ifdef SCYTALE_ERR_EN
    always @(negedge clk) begin
        if (mon_en && bus.err_o === 1'b1) err_pulses++;
    end
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        bus.data_i  = b;
        bus.valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic expect_str(input string s);
        for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && bus.busy === 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, bus.busy, 32'h0);
    endtask

    int b0;
    int e0;

    initial begin
        rst_n       = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.key     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 32'h0);
        check("rst_valid", bus.valid_o, 32'h0);
        check("rst_data", bus.data_o, 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // 3 columns x 2 rows: "adbecf" reads back as "abcdef".
        bus.key = {8'd3, 8'd2};
        send_str("adbecf");
        check("no_early_busy", bus.busy, 32'h0);
        expect_str("abcdef");
        b0 = busy_cycles; e0 = err_pulses;
        send_byte(START_DECRYPTION_TOKEN);
        check("busy_rise", bus.busy, 32'h1);
        check("valid_rise", bus.valid_o, 32'h1);
        wait_idle("idle_abcdef");
        check("busy_len_abcdef", busy_cycles - b0, 32'd6);
        check("drained_abcdef", sb.size(), 32'd0);
`ifdef SCYTALE_ERR_EN
        check("err_abcdef", err_pulses - e0, 32'd0);
`endif

        // Token on an empty buffer is ignored.
        b0 = busy_cycles;
        send_byte(START_DECRYPTION_TOKEN);
        repeat (10) @(posedge clk);
        #1;
        check("empty_token_busy", busy_cycles - b0, 32'd0);
        check("empty_token_state", bus.busy, 32'h0);

        // Full buffer, 5 columns x 10 rows; a 51st byte must be dropped.
        bus.key = {8'd5, 8'd10};
        e0 = err_pulses;
        for (int i = 0; i < MAX_NOF_CHARS; i++) send_byte(8'(i + 1));
        send_byte(8'h77);
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 5; c++) sb.push_back(8'(c * 10 + r + 1));
        b0 = busy_cycles;
        send_byte(START_DECRYPTION_TOKEN);
        check("busy_rise_full", bus.busy, 32'h1);
        wait_idle("idle_full");
        check("busy_len_full", busy_cycles - b0, 32'd50);
        check("drained_full", sb.size(), 32'd0);
`ifdef SCYTALE_ERR_EN
        check("err_full", err_pulses - e0, 32'd1);
`endif

        // Short message in a 2x2 grid: missing position pads with zero.
        bus.key = {8'd2, 8'd2};
        e0 = err_pulses;
        send_str("acb");
        sb.push_back("a"); sb.push_back("b"); sb.push_back("c"); sb.push_back(8'h00);
        b0 = busy_cycles;
        send_byte(START_DECRYPTION_TOKEN);
        wait_idle("idle_short");
        check("busy_len_short", busy_cycles - b0, 32'd4);
        check("drained_short", sb.size(), 32'd0);
`ifdef SCYTALE_ERR_EN
        check("err_short", err_pulses - e0, 32'd1);
`endif

        // Key change and traffic while busy have no effect.
        bus.key = {8'd2, 8'd2};
        send_str("wyxz");
        expect_str("wxyz");
        b0 = busy_cycles;
        send_byte(START_DECRYPTION_TOKEN);
        bus.key = {8'd3, 8'd2};
        send_byte("q");
        send_byte("r");
        send_byte(START_DECRYPTION_TOKEN);
        wait_idle("idle_keychg");
        check("busy_len_keychg", busy_cycles - b0, 32'd4);
        send_str("uxvywz");
        expect_str("uvwxyz");
        send_byte(START_DECRYPTION_TOKEN);
        wait_idle("idle_fresh");
        check("drained_fresh", sb.size(), 32'd0);

        // Zero column count: one busy cycle, no bytes.
        bus.key = {8'd0, 8'd4};
        send_str("pq");
        b0 = busy_cycles;
        send_byte(START_DECRYPTION_TOKEN);
        check("degen_busy", bus.busy, 32'h1);
        check("degen_valid", bus.valid_o, 32'h0);
        wait_idle("idle_degen");
        check("busy_len_degen", busy_cycles - b0, 32'd1);

        // Reset while the third plaintext byte is on the output.
        bus.key = {8'd3, 8'd2};
        send_str("adbecf");
        expect_str("abcdef");
        send_byte(START_DECRYPTION_TOKEN);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_busy", bus.busy, 32'h0);
        check("midrst_valid", bus.valid_o, 32'h0);
        check("midrst_data", bus.data_o, 32'h0);
        check("midrst_remaining", sb.size(), 32'd3);
        sb.delete();
        bus.key = {8'd2, 8'd2};
        send_str("wyxz");
        expect_str("wxyz");
        send_byte(START_DECRYPTION_TOKEN);
        wait_idle("idle_after_rst");

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
